// File: rtl/sb_pkg.sv
// Shared types and defaults for the posted-write store buffer.
package sb_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t addr;
    word_t data;
  } sb_entry_t;

  localparam int SB_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/store_buffer_if.sv
// Core-side store/load-probe signals and memory-side drain signals of the store buffer.
interface store_buffer_if
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int AW    = 32,
  parameter int DW    = 32
) ();

  localparam int CW = $clog2(DEPTH + 1);

  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          mem_ack;
  logic          empty;
  logic [CW-1:0] count;

  // master is the core/memory environment, slave is the buffer itself
  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_ack,
    input  st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wd, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_ack,
    output st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wd, empty, count
  );

endinterface

// File: rtl/sb_fwd_match.sv
// Load-forwarding lookup: word-address compare over occupied entries, youngest match wins.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [AW-1:0] i_addr [DEPTH],
  input  logic [DW-1:0] i_data [DEPTH],
  input  logic [DEPTH-1:0] i_valid,
  input  logic [PW-1:0] i_rdPtr,
  input  logic [AW-1:0] i_ldAddr,
  output logic          o_hit,
  output logic [DW-1:0] o_data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = i_rdPtr + PW'(k);
      if (i_valid[idx] && (i_addr[idx][AW-1:2] == i_ldAddr[AW-1:2])) begin
        o_hit  = 1'b1;
        o_data = i_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core's store port and data memory, with load forwarding.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic          clk,
  input logic          reset,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_valid;
  logic [PW-1:0]    w_offs;
  logic             w_hit;
  logic [DW-1:0]    w_fwdData;

  // Full/empty come from the counter only, so ready never depends on mem_ack
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.st_valid && !w_full;
  assign w_pop   = bus.mem_ack && !w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry contents are don't-care until written, so storage carries no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wrPtr] <= bus.st_addr;
      r_data[r_wrPtr] <= bus.st_data;
    end
  end

  always_comb begin
    w_valid = '0;
    w_offs  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_offs     = PW'(i) - r_rdPtr;
      w_valid[i] = (CW'(w_offs) < r_count);
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .i_addr   (r_addr),
    .i_data   (r_data),
    .i_valid  (w_valid),
    .i_rdPtr  (r_rdPtr),
    .i_ldAddr (bus.ld_addr),
    .o_hit    (w_hit),
    .o_data   (w_fwdData)
  );

  assign bus.st_ready = !w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = r_count;
  assign bus.mem_we   = !w_empty;
  assign bus.mem_addr = w_empty ? '0 : r_addr[r_rdPtr];
  assign bus.mem_wd   = w_empty ? '0 : r_data[r_rdPtr];
  assign bus.ld_hit   = w_hit;
  assign bus.ld_data  = w_fwdData;

endmodule
